arb_mux: RTL

- Parametrised N-channel arbitrated multiplexer with a registered output and valid/ready handshakes on every port.
- It generalises the fixed 2/3/4-input combinational selectors to NCH channels of WIDTH bits.
- Selection is made internally by round-robin or fixed-priority arbitration instead of an external select.
- Used to share one downstream port (e.g. the memory/bus port) between the instruction-fetch, load/store and debug request sources.

---
 rtl/arb_mux_pkg.sv | 13 +
 rtl/arb_mux_rr_arbiter.sv | 43 ++++
 rtl/arb_mux.sv | 95 +++++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arbitrated multiplexer: arbitration mode codes
// and the channel-index width helper.
package arb_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Index width for n channels; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin search starting at ptr_i, or fixed
// lowest-index-wins priority. Grant is one-hot and gated by en_i.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int SELW    = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            en_i,
    output logic [NCH-1:0]  grant_o,
    output logic [SELW-1:0] idx_o
);

    // Channel examined at search position k.
    function automatic logic [SELW-1:0] slot(input logic [SELW-1:0] ptr, input int k);
        int c;
        c = (ARB_MODE == ARB_FIXED) ? k : (int'(ptr) + k) % NCH;
        return SELW'(c);
    endfunction

    logic found;

    // NOTE: every output of this block gets a default before the search loop,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && req_i[slot(ptr_i, k)]) begin
                found                   = 1'b1;
                idx_o                   = slot(ptr_i, k);
                grant_o[slot(ptr_i, k)] = 1'b1;
            end
        end
        // The index still tracks the winner so the output stage can load it.
        if (!en_i) grant_o = '0;
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with a registered output stage and
// valid/ready handshakes on every input channel and on the output.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int SELW    = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             load;
    logic             any_valid;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] sel_data;

    // The output stage accepts a new word when empty or draining this cycle.
    assign load      = ~out_valid_q | out_ready;
    assign any_valid = |in_valid;

    rr_arbiter #(
        .NCH      (NCH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .en_i    (load & ~reset),
        .grant_o (grant),
        .idx_o   (g)
    );

    assign in_ready = grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = sel_data;
                out_sel_d  = g;
                // Pointer moves only on a real grant, to the channel after the winner.
                if (ARB_MODE == ARB_RR) begin
                    ptr_d = (g == SELW'(NCH - 1)) ? '0 : g + SELW'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and checked inside the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
